// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // Index width for an n-entry select; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above rr_ptr, with wrap.
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     off;
  logic [IDX_W:0]     sum;

  always_comb begin
    // Rotate so bit 0 is the producer at rr_ptr; the lowest set bit is the winner.
    rot   = NUM_REQ'({req, req} >> rr_ptr);
    found = 1'b0;
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = (IDX_W + 1)'(i);
      end
    end
    sum = {1'b0, rr_ptr} + off;
    if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
    index = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Optional statistics counters are enabled with `define FIFO_ARB_STATS_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ARB_IDLE | no owner; pick next valid producer from rr_ptr (1 cycle)
//   ARB_OWN  | owner may write until last, burst cap, or valid drops
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  parameter  int STAT_W    = 16,
  localparam int IDX_W     = idx_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic                      grant_active,
`ifdef FIFO_ARB_STATS_EN
  output logic [IDX_W-1:0]          grant_id,
  output logic [NUM_REQ*STAT_W-1:0] stat_accept_cnt,
  output logic [STAT_W-1:0]         stat_stall_cnt
`else
  output logic [IDX_W-1:0]          grant_id
`endif
);

  localparam int                BC_W       = idx_width(MAX_BURST + 1);
  localparam logic [BC_W-1:0]   BURST_LAST = BC_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_REQ - 1);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [BC_W-1:0]  burst_cnt, burst_cnt_nxt;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              own_valid;
  logic              own_last;
  logic [DATA_W-1:0] own_data;
  logic              accept;

  fifo_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_idx)
  );

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    accept        = 1'b0;
    req_ready     = '0;
    fifo_wr_en    = 1'b0;
    fifo_data_in  = '0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          owner_nxt     = pick_idx;
          burst_cnt_nxt = '0;
          state_nxt     = ARB_OWN;
        end
      end
      ARB_OWN: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner == IDX_W'(i)) req_ready[i] = !fifo_full;
        end
        accept     = own_valid && !fifo_full;
        fifo_wr_en = accept;
        if (accept) begin
          fifo_data_in  = own_data;
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
        // A full FIFO only stalls; the grant ends on last, burst cap or dropped valid.
        if (!own_valid || (accept && (own_last || burst_cnt == BURST_LAST))) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = (owner == LAST_IDX) ? '0 : owner + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    // Nothing is handed out while reset is asserted, even mid-burst.
    if (rst) begin
      accept       = 1'b0;
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_data_in = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  assign grant_active = (state == ARB_OWN) && !rst;
  assign grant_id     = owner;

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] acc_cnt [NUM_REQ];
  logic [STAT_W-1:0] stall_cnt;
  logic              stall;

  assign stall = (state == ARB_OWN) && own_valid && fifo_full && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) acc_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && owner == IDX_W'(i) && acc_cnt[i] != '1) acc_cnt[i] <= acc_cnt[i] + 1'b1;
      end
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_accept_cnt[g*STAT_W +: STAT_W] = acc_cnt[g];
  end
  assign stat_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter; stats checks compile in with FIFO_ARB_STATS_EN.
module tb_fifo_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;
  logic        grant_active;
  logic [1:0]  grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_accept_cnt;
  logic [3:0]  stat_stall_cnt;
`endif

  fifo_write_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .MAX_BURST (4),
    .STAT_W    (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .grant_active    (grant_active),
`ifdef FIFO_ARB_STATS_EN
    .grant_id        (grant_id),
    .stat_accept_cnt (stat_accept_cnt),
    .stat_stall_cnt  (stat_stall_cnt)
`else
    .grant_id        (grant_id)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] pq_data [4][$];
  bit         pq_last [4][$];
  bit         full_q  [$];
  logic [7:0] sb_q    [$];

  bit         tr_wr  [64];
  bit         tr_act [64];
  logic [1:0] tr_gid [64];
  logic [3:0] tr_rdy [64];

  // Producers present their queue heads; data leaves a queue only on valid&&ready.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      logic [3:0] hs;
      logic [7:0] exp_d;
      for (int i = 0; i < 4; i++) begin
        if (pq_data[i].size() > 0) begin
          req_valid[i]         = 1'b1;
          req_data[i*8 +: 8]   = pq_data[i][0];
          req_last[i]          = pq_last[i][0];
        end else begin
          req_valid[i]         = 1'b0;
          req_data[i*8 +: 8]   = 8'h00;
          req_last[i]          = 1'b0;
        end
      end
      fifo_full = (full_q.size() > 0) ? full_q.pop_front() : 1'b0;
      #1;
      tr_wr[c]  = fifo_wr_en;
      tr_act[c] = grant_active;
      tr_gid[c] = grant_id;
      tr_rdy[c] = req_ready;
      hs = req_valid & req_ready;
      n_cmp++;
      if (fifo_wr_en) begin
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_write: got unexpected write data %h, required no write", fifo_data_in);
        end else begin
          exp_d = sb_q.pop_front();
          if (fifo_data_in !== exp_d) begin
            n_err++;
            $display("FAIL sb_data: got %h, required %h", fifo_data_in, exp_d);
          end
        end
      end else if (fifo_data_in !== 8'h00) begin
        n_err++;
        $display("FAIL idle_data: got %h, required 00", fifo_data_in);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) begin
          void'(pq_data[i].pop_front());
          void'(pq_last[i].pop_front());
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      pq_data[i].push_back(8'h10 + 8'(i));
      pq_last[i].push_back(1'b1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    run(2);
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if (tr_act[c] !== 1'b0 || tr_wr[c] !== 1'b0 || tr_rdy[c] !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_outputs: cycle %0d got act=%b wr=%b rdy=%b, required 0 0 0000",
                 c, tr_act[c], tr_wr[c], tr_rdy[c]);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) sb_q.push_back(8'h10 + 8'(i));
    run(8);
    n_cmp++;
    if (tr_act[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_idle: got act=%b, required 0", tr_act[0]);
    end
    n_cmp++;
    if (tr_act[1] !== 1'b1 || tr_gid[1] !== 2'd0 || tr_rdy[1] !== 4'b0001 || tr_wr[1] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_grant: got act=%b gid=%0d rdy=%b wr=%b, required 1 0 0001 1",
               tr_act[1], tr_gid[1], tr_rdy[1], tr_wr[1]);
    end
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL reset_drain: got %0d pending writes, required 0", sb_q.size());
    end
  endtask

  task automatic test_round_robin();
    int exp_gid[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) begin
        pq_data[i].push_back(8'h20 + 8'(b * 16 + i));
        pq_last[i].push_back(1'b1);
      end
    end
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 4; i++) sb_q.push_back(8'h20 + 8'(b * 16 + i));
    run(16);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (tr_gid[2*k+1] !== 2'(exp_gid[k]) || tr_act[2*k+1] !== 1'b1) begin
        n_err++;
        $display("FAIL rr_grant: slot %0d got gid=%0d act=%b, required %0d 1",
                 k, tr_gid[2*k+1], tr_act[2*k+1], exp_gid[k]);
      end
    end
    for (int c = 0; c < 16; c++) begin
      n_cmp++;
      if (tr_wr[c] !== bit'(c % 2)) begin
        n_err++;
        $display("FAIL rr_wr_pattern: cycle %0d got %b, required %0d", c, tr_wr[c], c % 2);
      end
    end
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL rr_drain: got %0d pending writes, required 0", sb_q.size());
    end
  endtask

  task automatic test_burst_cap();
    int exp_wr[15]  = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    int exp_act[15] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    for (int k = 0; k < 10; k++) begin
      pq_data[1].push_back(8'h40 + 8'(k));
      pq_last[1].push_back(1'b0);
      sb_q.push_back(8'h40 + 8'(k));
    end
    run(15);
    for (int c = 0; c < 15; c++) begin
      n_cmp++;
      if (tr_wr[c] !== bit'(exp_wr[c]) || tr_act[c] !== bit'(exp_act[c])) begin
        n_err++;
        $display("FAIL burst_pattern: cycle %0d got wr=%b act=%b, required %0d %0d",
                 c, tr_wr[c], tr_act[c], exp_wr[c], exp_act[c]);
      end
      if (exp_act[c] == 1) begin
        n_cmp++;
        if (tr_gid[c] !== 2'd1) begin
          n_err++;
          $display("FAIL burst_gid: cycle %0d got %0d, required 1", c, tr_gid[c]);
        end
      end
    end
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL burst_drain: got %0d pending writes, required 0", sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    int exp_wr[13] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0};
    for (int k = 0; k < 6; k++) begin
      pq_data[0].push_back(8'h50 + 8'(k));
      pq_last[0].push_back(1'b0);
      sb_q.push_back(8'h50 + 8'(k));
    end
    for (int c = 0; c < 6; c++) full_q.push_back(c >= 3);
    run(13);
    for (int c = 0; c < 13; c++) begin
      n_cmp++;
      if (tr_wr[c] !== bit'(exp_wr[c])) begin
        n_err++;
        $display("FAIL bp_wr_pattern: cycle %0d got %b, required %0d", c, tr_wr[c], exp_wr[c]);
      end
    end
    for (int c = 3; c < 6; c++) begin
      n_cmp++;
      if (tr_rdy[c] !== 4'b0000 || tr_act[c] !== 1'b1 || tr_gid[c] !== 2'd0) begin
        n_err++;
        $display("FAIL bp_stall: cycle %0d got rdy=%b act=%b gid=%0d, required 0000 1 0",
                 c, tr_rdy[c], tr_act[c], tr_gid[c]);
      end
    end
    n_cmp++;
    if (tr_act[8] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_burst_end: got act=%b after 4 beats, required 0", tr_act[8]);
    end
`ifdef FIFO_ARB_STATS_EN
    n_cmp++;
    if (stat_stall_cnt !== 4'd3) begin
      n_err++;
      $display("FAIL bp_stall_cnt: got %0d, required 3", stat_stall_cnt);
    end
`endif
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL bp_drain: got %0d pending writes, required 0", sb_q.size());
    end
  endtask

  task automatic test_owner_drop();
    pq_data[2].push_back(8'h70);
    pq_last[2].push_back(1'b0);
    pq_data[3].push_back(8'h71);
    pq_last[3].push_back(1'b1);
    sb_q.push_back(8'h70);
    sb_q.push_back(8'h71);
    run(6);
    n_cmp++;
    if (tr_gid[1] !== 2'd2 || tr_wr[1] !== 1'b1) begin
      n_err++;
      $display("FAIL drop_grant2: got gid=%0d wr=%b, required 2 1", tr_gid[1], tr_wr[1]);
    end
    n_cmp++;
    if (tr_act[2] !== 1'b1 || tr_wr[2] !== 1'b0 || tr_act[3] !== 1'b0) begin
      n_err++;
      $display("FAIL drop_release: got act2=%b wr2=%b act3=%b, required 1 0 0",
               tr_act[2], tr_wr[2], tr_act[3]);
    end
    n_cmp++;
    if (tr_act[4] !== 1'b1 || tr_gid[4] !== 2'd3 || tr_wr[4] !== 1'b1) begin
      n_err++;
      $display("FAIL drop_grant3: got act=%b gid=%0d wr=%b, required 1 3 1",
               tr_act[4], tr_gid[4], tr_wr[4]);
    end
  endtask

  task automatic test_reset_mid_burst_and_stats();
    int n_wr = 0;
    for (int k = 0; k < 6; k++) begin
      pq_data[1].push_back(8'h80 + 8'(k));
      pq_last[1].push_back(1'b0);
    end
    sb_q.push_back(8'h80);
    run(2);
    rst = 1'b1;
    run(1);
    n_cmp++;
    if (tr_wr[0] !== 1'b0 || tr_act[0] !== 1'b0 || tr_rdy[0] !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_reset: got wr=%b act=%b rdy=%b, required 0 0 0000",
               tr_wr[0], tr_act[0], tr_rdy[0]);
    end
    for (int i = 0; i < 4; i++) begin
      pq_data[i].delete();
      pq_last[i].delete();
    end
    rst = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    n_cmp++;
    if (stat_accept_cnt !== 16'h0000 || stat_stall_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL stats_clear: got acc=%h stall=%0d, required 0000 0", stat_accept_cnt, stat_stall_cnt);
    end
`endif
    for (int k = 0; k < 20; k++) begin
      pq_data[0].push_back(8'h90 + 8'(k));
      pq_last[0].push_back(1'b0);
      sb_q.push_back(8'h90 + 8'(k));
    end
    run(26);
    for (int c = 0; c < 26; c++) n_wr += int'(tr_wr[c]);
    n_cmp++;
    if (n_wr !== 20 || sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL long_run: got %0d writes, %0d pending, required 20 0", n_wr, sb_q.size());
    end
`ifdef FIFO_ARB_STATS_EN
    n_cmp++;
    if (stat_accept_cnt[3:0] !== 4'd15) begin
      n_err++;
      $display("FAIL stats_sat: got %0d, required 15", stat_accept_cnt[3:0]);
    end
    n_cmp++;
    if (stat_accept_cnt[15:4] !== 12'h000 || stat_stall_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL stats_others: got acc=%h stall=%0d, required 000 0",
               stat_accept_cnt[15:4], stat_stall_cnt);
    end
`endif
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    test_reset();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_owner_drop();
    test_reset_mid_burst_and_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1);
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Shares one fifo_buffer write port among NUM_REQ producers, using valid/ready handshakes on each producer.
Grants one producer at a time with round-robin fairness and a per-grant burst cap.
Drives the FIFO's write enable and write data, and respects its full flag.
Sits directly in front of the FIFO write side. The FIFO read side is untouched.

Parameters:
NUM_REQ, 4, number of producers (>=2)
DATA_W, 8, data width; matches the FIFO data width
MAX_BURST, 4, maximum beats accepted per grant (>=1)
STAT_W, 16, statistics counter width (used only with FIFO_ARB_STATS_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-producer data valid
req_data  in  NUM_REQ*DATA_W  per-producer data; producer i uses slice [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  per-producer end-of-packet marker, qualified by valid
req_ready  out  NUM_REQ  per-producer accept
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO write enable
fifo_data_in  out  DATA_W  FIFO write data
grant_active  out  1  a producer currently owns the port
grant_id  out  $clog2(NUM_REQ)  current/last owner index

Behaviour:
- Reset: rst=1 sampled at clk forces the following.
  - State: state=ARB_IDLE, owner=0, rr_ptr=0, burst_cnt=0.
  - Outputs: grant_active=0, grant_id=0, req_ready=0, fifo_wr_en=0, fifo_data_in=0.
  - Stats (if enabled): cleared to 0.
- Reset mid-burst abandons the grant. No write is issued in the reset cycle.
- ARB_IDLE:
  - No ready is asserted.
  - If any req_valid is high, pick the first valid index scanning upward from rr_ptr with wrap. Register it as owner, set burst_cnt=0, go to ARB_OWN next cycle.
  - Arbitration costs exactly 1 idle cycle per grant.
- ARB_OWN:
  - req_ready[owner]=!fifo_full. All other ready outputs are 0.
  - accept = req_valid[owner] && !fifo_full.
  - fifo_wr_en = accept, combinational in the same cycle.
  - fifo_data_in = owner's data slice when accept, else 0.
  - On accept, burst_cnt increments.
- Release from ARB_OWN to ARB_IDLE when any of these holds:
  - accept && req_last[owner];
  - accept && burst_cnt==MAX_BURST-1;
  - !req_valid[owner].
- On release: rr_ptr = owner+1, wrapping to 0 after NUM_REQ-1.
- fifo_full in ARB_OWN with owner valid:
  - stall: grant held, burst_cnt unchanged, no write;
  - fifo_full does not by itself release the grant.
- grant_active = (state==ARB_OWN). grant_id is registered owner and holds its value in ARB_IDLE.
- MAX_BURST=1: every accept releases.
- Non-owner producers see ready=0. Their valid is ignored except for arbitration.

Optional Feature:
Macro FIFO_ARB_STATS_EN.
- Defined: adds these output ports.
  - stat_accept_cnt [NUM_REQ*STAT_W]: per-producer count of accepts.
  - stat_stall_cnt [STAT_W]: counts ARB_OWN cycles with req_valid[owner] && fifo_full.
  - Both are saturating at all-ones and cleared by rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg: enum arb_state_e {ARB_IDLE, ARB_OWN}; a localparam helper for the index width ($clog2(NUM_REQ)).
- One sub-module fifo_arb_rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, index.

Test Plan:
1. Reset: rst=1 for 2 cycles with all req_valid=1.
   - During reset: grant_active=0, fifo_wr_en=0, req_ready=0.
   - First clk after rst=0: grant to 0. Following cycle: req_ready[0]=1 and fifo_wr_en=1.
2. Round-robin: all 4 producers valid, req_last=1 every beat.
   - grant_id sequence 0,1,2,3,0.
   - fifo_wr_en pattern 0,1,0,1,...
   - FIFO receives data in producer order.
3. Burst cap: only req1 valid, 10 beats, req_last=0, MAX_BURST=4.
   - Grants of 4, 4, 2 beats, each separated by 1 idle cycle.
   - Data order preserved; re-grant goes to 1 (rr_ptr=2 wraps to 1).
4. Backpressure: fifo_full=1 for 3 cycles after beat 2 of a grant.
   - req_ready=0, fifo_wr_en=0, grant_id unchanged.
   - Burst still ends after 4 total beats.
   - With macro: stat_stall_cnt=3.
5. Owner drops valid: req2 granted, sends 1 beat, deasserts valid, req3 valid.
   - Release the next cycle; then 1 idle cycle; then grant_id=3.
6. Stats saturation with STAT_W=4 and macro defined: 20 accepts from req0.
   - stat_accept_cnt[0]=15; the other counters stay 0.
